// File: rtl/fft_spectrum_buf_pkg.sv
// rtl/fft_spectrum_buf_pkg.sv - shared sizing, FSM encoding and saturating abs helper
package fft_spectrum_buf_pkg;

  localparam int N_BINS  = 128;
  localparam int DW      = 16;
  localparam int SHIFT   = 4;
  localparam int MAX_LEN = 250;
  localparam int LEN_W   = 16;
  localparam int ADDR_W  = $clog2(N_BINS);
  localparam int IDX_W   = ADDR_W + 1;

  localparam logic [IDX_W-1:0] N_BINS_IDX = IDX_W'(N_BINS);
  localparam logic [DW:0]      MAX_LEN_M  = (DW+1)'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CAPT = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  // The most negative input has no positive twin, so it clamps to the largest positive value.
  function automatic logic [DW-1:0] abs_sat(input logic [DW-1:0] x);
    logic [DW-1:0] neg;
    neg = ~x + DW'(1);
    if (x == {1'b1, {(DW-1){1'b0}}})
      abs_sat = {1'b0, {(DW-1){1'b1}}};
    else if (x[DW-1])
      abs_sat = neg;
    else
      abs_sat = x;
  endfunction

endpackage

// File: rtl/fft_mag_approx.sv
// rtl/fft_mag_approx.sv - 3-stage |re|,|im| -> max+min/2 -> shift/saturate bar height pipe
module fft_mag_approx
  import fft_spectrum_buf_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic [DW-1:0]    in_real,
  input  logic [DW-1:0]    in_imag,
  output logic             out_valid,
  output logic             out_sop,
  output logic             out_eop,
  output logic [LEN_W-1:0] out_len
);

  logic [2:0]       vld_q, vld_d;
  logic [2:0]       sop_q, sop_d;
  logic [2:0]       eop_q, eop_d;
  logic [DW-1:0]    a_q, a_d;
  logic [DW-1:0]    b_q, b_d;
  logic [DW:0]      m_q, m_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [DW-1:0]    mx, mn;
  logic [DW:0]      m_sh;

  always_comb begin
    vld_d = {vld_q[1:0], in_valid};
    sop_d = {sop_q[1:0], in_valid & in_sop};
    eop_d = {eop_q[1:0], in_valid & in_eop};
    a_d   = abs_sat(in_real);
    b_d   = abs_sat(in_imag);
    mx    = (a_q >= b_q) ? a_q : b_q;
    mn    = (a_q >= b_q) ? b_q : a_q;
    m_d   = {1'b0, mx} + ({1'b0, mn} >> 1);
    m_sh  = m_q >> SHIFT;
    len_d = (m_sh > MAX_LEN_M) ? LEN_W'(MAX_LEN) : m_sh[LEN_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      sop_q <= '0;
      eop_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      m_q   <= '0;
      len_q <= '0;
    end else begin
      vld_q <= vld_d;
      sop_q <= sop_d;
      eop_q <= eop_d;
      a_q   <= a_d;
      b_q   <= b_d;
      m_q   <= m_d;
      len_q <= len_d;
    end
  end

  assign out_valid = vld_q[2];
  assign out_sop   = sop_q[2];
  assign out_eop   = eop_q[2];
  assign out_len   = len_q;

endmodule

// File: rtl/fft_spectrum_buf.sv
// rtl/fft_spectrum_buf.sv - FFT bins to bar heights, ping-pong frame capture, tear-free display reads
module fft_spectrum_buf
  import fft_spectrum_buf_pkg::*;
(
  input  logic          lcd_clk,
  input  logic          sys_rst_n,
  input  logic          fft_valid,
  input  logic          fft_sop,
  input  logic          fft_eop,
  input  logic [DW-1:0] fft_real,
  input  logic [DW-1:0] fft_imag,
  output logic          fft_ready,
  input  logic [6:0]    line_cnt,
  input  logic          data_req,
  input  logic          wr_over,
  output logic [15:0]   line_length,
  output logic          swap_pulse,
  output logic          err_short
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               wr_bank_q, wr_bank_d;
  logic               rd_valid_q, rd_valid_d;
  logic               pend_q, pend_d;
  logic               swap_q, swap_d;
  logic               err_q, err_d;
  logic [LEN_W-1:0]   len_q, len_d;

  logic               p_valid, p_sop, p_eop;
  logic [LEN_W-1:0]   p_len;
  logic               we;
  logic [ADDR_W:0]    waddr;
  logic [ADDR_W:0]    rd_addr;
  logic               line_ok;
  logic [LEN_W-1:0]   mem [0:2*N_BINS-1];

  assign fft_ready = (state_q != S_WAIT);

  fft_mag_approx u_mag (
    .clk       (lcd_clk),
    .rst_n     (sys_rst_n),
    .in_valid  (fft_valid & fft_ready),
    .in_sop    (fft_sop),
    .in_eop    (fft_eop),
    .in_real   (fft_real),
    .in_imag   (fft_imag),
    .out_valid (p_valid),
    .out_sop   (p_sop),
    .out_eop   (p_eop),
    .out_len   (p_len)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wr_bank_d  = wr_bank_q;
    rd_valid_d = rd_valid_q;
    pend_d     = pend_q;
    swap_d     = 1'b0;
    err_d      = 1'b0;
    we         = 1'b0;
    waddr      = {wr_bank_q, idx_q[ADDR_W-1:0]};
    case (state_q)
      S_IDLE: begin
        if (wr_over) pend_d = 1'b1;
        if (p_valid && p_sop) begin
          we      = 1'b1;
          waddr   = {wr_bank_q, {ADDR_W{1'b0}}};
          idx_d   = IDX_W'(1);
          state_d = S_CAPT;
          if (p_eop) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_CAPT: begin
        if (wr_over) pend_d = 1'b1;
        if (p_valid) begin
          if (p_sop) begin
            // A new sop abandons the partial frame and restarts at bin 0.
            we    = 1'b1;
            waddr = {wr_bank_q, {ADDR_W{1'b0}}};
            idx_d = IDX_W'(1);
            err_d = 1'b1;
            if (p_eop) state_d = S_IDLE;
          end else begin
            we    = (idx_q < N_BINS_IDX);
            idx_d = (idx_q < N_BINS_IDX) ? idx_q + IDX_W'(1) : idx_q;
            if (p_eop) begin
              if (idx_q + IDX_W'(1) >= N_BINS_IDX) begin
                state_d = S_WAIT;
              end else begin
                err_d   = 1'b1;
                state_d = S_IDLE;
              end
            end
          end
        end
      end
      S_WAIT: begin
        if (pend_q || wr_over) begin
          wr_bank_d  = ~wr_bank_q;
          rd_valid_d = 1'b1;
          pend_d     = 1'b0;
          swap_d     = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reads use the current wr_bank_q, so a swap in the same cycle still serves the old frame.
  always_comb begin
    line_ok = ({1'b0, line_cnt} < N_BINS_IDX);
    rd_addr = {~wr_bank_q, line_cnt};
    len_d   = len_q;
    if (data_req)
      len_d = (rd_valid_q && line_ok) ? mem[rd_addr] : '0;
  end

  always_ff @(posedge lcd_clk) begin
    if (we) mem[waddr] <= p_len;
  end

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      wr_bank_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      pend_q     <= 1'b0;
      swap_q     <= 1'b0;
      err_q      <= 1'b0;
      len_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wr_bank_q  <= wr_bank_d;
      rd_valid_q <= rd_valid_d;
      pend_q     <= pend_d;
      swap_q     <= swap_d;
      err_q      <= err_d;
      len_q      <= len_d;
    end
  end

  assign line_length = len_q;
  assign swap_pulse  = swap_q;
  assign err_short   = err_q;

endmodule

// File: tb/tb_fft_spectrum_buf.sv
// tb/tb_fft_spectrum_buf.sv - directed and randomized frames against a behavioural bar-height model
module tb_fft_spectrum_buf;

  logic        lcd_clk = 1'b0;
  logic        sys_rst_n;
  logic        fft_valid, fft_sop, fft_eop;
  logic [15:0] fft_real, fft_imag;
  logic        fft_ready;
  logic [6:0]  line_cnt;
  logic        data_req, wr_over;
  logic [15:0] line_length;
  logic        swap_pulse, err_short;

  int checks = 0;
  int errors = 0;
  int re_a[128], im_a[128];
  int cap[128], disp[128];
  bit disp_valid = 0;

  always #5 lcd_clk = ~lcd_clk;

  fft_spectrum_buf dut (
    .lcd_clk     (lcd_clk),
    .sys_rst_n   (sys_rst_n),
    .fft_valid   (fft_valid),
    .fft_sop     (fft_sop),
    .fft_eop     (fft_eop),
    .fft_real    (fft_real),
    .fft_imag    (fft_imag),
    .fft_ready   (fft_ready),
    .line_cnt    (line_cnt),
    .data_req    (data_req),
    .wr_over     (wr_over),
    .line_length (line_length),
    .swap_pulse  (swap_pulse),
    .err_short   (err_short)
  );

  function automatic int exp_len(int re, int im);
    int a, b, mx, mn, m;
    a = (re < 0) ? -re : re;
    b = (im < 0) ? -im : im;
    if (a > 32767) a = 32767;
    if (b > 32767) b = 32767;
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    m = (mx + mn / 2) / 16;
    return (m > 250) ? 250 : m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge lcd_clk);
    #1;
  endtask

  task automatic rand_frame();
    for (int k = 0; k < 128; k++) begin
      re_a[k] = int'($urandom_range(0, 8191)) - 4096;
      im_a[k] = int'($urandom_range(0, 8191)) - 4096;
    end
    re_a[0] = -32768;
    im_a[0] = 5;
  endtask

  task automatic send_frame(input int n, input int wr_at, input bit with_eop);
    for (int i = 0; i < n; i++) begin
      fft_valid = 1'b1;
      fft_sop   = (i == 0);
      fft_eop   = with_eop && (i == n - 1);
      fft_real  = 16'(re_a[i]);
      fft_imag  = 16'(im_a[i]);
      wr_over   = (i == wr_at);
      tick();
    end
    fft_valid = 1'b0;
    fft_sop   = 1'b0;
    fft_eop   = 1'b0;
    wr_over   = 1'b0;
  endtask

  task automatic model_capture();
    for (int k = 0; k < 128; k++) cap[k] = exp_len(re_a[k], im_a[k]);
  endtask

  task automatic model_swap();
    for (int k = 0; k < 128; k++) disp[k] = cap[k];
    disp_valid = 1;
  endtask

  task automatic check_line(input string tag, input int lc);
    int expv;
    expv = disp_valid ? disp[lc] : 0;
    line_cnt = 7'(lc);
    data_req = 1'b1;
    tick();
    data_req = 1'b0;
    check(tag, line_length, expv);
  endtask

  task automatic wait_ready_low(input string tag);
    int n;
    n = -1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (!fft_ready) begin
        n = c;
        break;
      end
    end
    check(tag, n, 2);
  endtask

  task automatic do_swap(input string tag);
    wr_over = 1'b1;
    tick();
    wr_over = 1'b0;
    check({tag, "_swap"}, swap_pulse, 1'b1);
    check({tag, "_ready_back"}, fft_ready, 1'b1);
    model_swap();
    tick();
    check({tag, "_swap_1cyc"}, swap_pulse, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int errs, swaps, lows, low_first, swap_at, lc, old;
    sys_rst_n = 1'b0;
    fft_valid = 1'b0; fft_sop = 1'b0; fft_eop = 1'b0;
    fft_real = '0; fft_imag = '0;
    line_cnt = '0; data_req = 1'b0; wr_over = 1'b0;
    repeat (3) tick();
    check("rst_ready", fft_ready, 1'b1);
    check("rst_len", line_length, 16'd0);
    check("rst_swap", swap_pulse, 1'b0);
    check("rst_err", err_short, 1'b0);
    sys_rst_n = 1'b1;
    tick();
    check_line("no_frame_yet", 5);

    // Ramp frame: bar height equals bin index.
    for (int k = 0; k < 128; k++) begin re_a[k] = 16 * k; im_a[k] = 0; end
    send_frame(128, -1, 1'b1);
    model_capture();
    wait_ready_low("t1_wait_latency");
    check("t1_no_early_swap", swap_pulse, 1'b0);
    do_swap("t1");
    check_line("t1_line10", 10);
    check_line("t1_line127", 127);
    check_line("t1_line0", 0);

    // Saturation to MAX_LEN.
    for (int k = 0; k < 128; k++) begin re_a[k] = -4000; im_a[k] = 3000; end
    send_frame(128, -1, 1'b1);
    model_capture();
    wait_ready_low("t2_wait_latency");
    do_swap("t2");
    check_line("t2_line0", 0);
    check_line("t2_line64", 64);
    check_line("t2_line127", 127);

    // Random frame; reads while waiting still show the previous frame.
    rand_frame();
    send_frame(128, -1, 1'b1);
    model_capture();
    wait_ready_low("rnd_wait_latency");
    check_line("rnd_old_frame", 3);
    do_swap("rnd");
    check_line("rnd_line0", 0);
    check_line("rnd_line127", 127);
    for (int i = 0; i < 6; i++) check_line("rnd_line", int'($urandom_range(0, 127)));

    // Short frame: err pulse, no swap, no stall.
    rand_frame();
    send_frame(60, -1, 1'b1);
    errs = 0; swaps = 0; lows = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (err_short) errs++;
      if (swap_pulse) swaps++;
      if (!fft_ready) lows++;
    end
    check("t3_err_pulses", errs, 1);
    check("t3_no_swap", swaps, 0);
    check("t3_no_stall", lows, 0);
    rand_frame();
    send_frame(128, -1, 1'b1);
    model_capture();
    wait_ready_low("t3_next_wait");
    do_swap("t3");
    for (int i = 0; i < 4; i++) check_line("t3_line", int'($urandom_range(0, 127)));

    // wr_over during capture is remembered and swaps one cycle after S_WAIT entry.
    rand_frame();
    send_frame(128, 50, 1'b1);
    model_capture();
    low_first = -1; swap_at = -1; lows = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (!fft_ready) begin
        lows++;
        if (low_first < 0) low_first = c;
      end
      if (swap_pulse && swap_at < 0) swap_at = c;
    end
    check("t4_wait_entry", low_first, 2);
    check("t4_ready_low_cycles", lows, 1);
    check("t4_swap_at", swap_at, 3);
    model_swap();
    for (int i = 0; i < 4; i++) check_line("t4_line", int'($urandom_range(0, 127)));

    // No wr_over: stall held, then a swap coincident with a read.
    rand_frame();
    send_frame(128, -1, 1'b1);
    model_capture();
    wait_ready_low("t5_wait_latency");
    lows = 0; swaps = 0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (fft_ready) lows++;
      if (swap_pulse) swaps++;
    end
    check("t5_ready_held_low", lows, 0);
    check("t5_no_swap", swaps, 0);
    lc = int'($urandom_range(0, 127));
    old = disp[lc];
    line_cnt = 7'(lc);
    data_req = 1'b1;
    wr_over = 1'b1;
    tick();
    data_req = 1'b0;
    wr_over = 1'b0;
    check("t5_read_pre_swap", line_length, old);
    check("t5_swap", swap_pulse, 1'b1);
    check("t5_ready_back", fft_ready, 1'b1);
    model_swap();
    check_line("t5_read_post_swap", lc);

    // Reset in the middle of a capture.
    rand_frame();
    send_frame(40, -1, 1'b0);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("t6_rst_ready", fft_ready, 1'b1);
    check("t6_rst_len", line_length, 16'd0);
    check("t6_rst_swap", swap_pulse, 1'b0);
    check("t6_rst_err", err_short, 1'b0);
    tick();
    sys_rst_n = 1'b1;
    disp_valid = 0;
    tick();
    check_line("t6_zero_bars", 10);
    rand_frame();
    send_frame(128, -1, 1'b1);
    model_capture();
    wait_ready_low("t6_wait_latency");
    do_swap("t6");
    check_line("t6_line0", 0);
    check_line("t6_line", int'($urandom_range(1, 127)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
